toggle_seq_ctrl: RTL and testbench
==================================

Name: toggle_seq_ctrl

Overview:
- Controller that sequences a bank of WIDTH T-type storage bits as a bounded up/down counter.
- Each cycle it computes the per-bit toggle enables that advance the bank by one step.
- A small FSM handles start, pause and resume, terminal detection, and a completion pulse.
- Sits between lab-level control inputs (buttons or a bench) and the T flip-flop datapath.

Parameters:
- WIDTH, 4, number of T-type bits in the bank (counter width); legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled; begins a run from IDLE, or resumes from HOLD.
- stop  input  1  level-sampled; pauses from RUN, or aborts from HOLD.
- dir  input  1  0 = count up 0→limit, 1 = count down limit→0; latched on start from IDLE.
- limit  input  WIDTH  terminal or initial bound; latched on start from IDLE.
- toggle  output  WIDTH  per-bit toggle enables applied to the bank this cycle (combinational from state and count).
- count  output  WIDTH  current bank value (the T-bit register contents).
- busy  output  1  high in RUN or HOLD.
- done  output  1  high for exactly one cycle, in state DONE.

Behaviour:
- Reset (asynchronous, any time): state=IDLE, count=0, latched dir=0, latched limit=0, toggle=0, busy=0, done=0. A mid-run reset discards the run with no done pulse.
- Bank storage: each bit behaves as a T flip-flop. At every rising edge, count <= count ^ toggle, except when the FSM loads an initial value (IDLE→RUN).
- Toggle generation, in RUN only and when count != terminal:
  - up: toggle[0]=1; toggle[i]=&count[i-1:0].
  - down: toggle[0]=1; toggle[i]=~|count[i-1:0].
  - In every other state, or at terminal, toggle=0.
- Terminal: 'limit' when up, 0 when down (latched values).
- FSM states: IDLE, RUN, HOLD, DONE.
- IDLE:
  - start=1 and stop=0 → RUN. Latch dir and limit; count loads 0 (up) or limit (down) at the same edge.
  - Otherwise stay; count holds its last value.
  - stop is ignored.
- RUN:
  - stop=1 → HOLD (stop wins over start); toggle is still applied on that edge, so one final step occurs.
  - Else if count==terminal → DONE; toggle=0, so count is unchanged.
  - Else stay, advancing one step per cycle.
- HOLD:
  - toggle=0.
  - stop=1 → IDLE (abort, count retained, no done).
  - Else start=1 → RUN.
  - Else stay.
- DONE: done=1, toggle=0 → IDLE unconditionally next edge. start and stop are ignored.
- Latency:
  - start edge to first count change: 1 cycle.
  - A run of N steps reaches terminal N edges after the start edge; DONE is entered on the following edge.
- limit=0: start enters RUN with count==terminal, goes to DONE on the next edge, and count stays 0.
- limit or dir changes mid-run have no effect; only the latched copies are used.
- No wrap-around is possible: terminal detection always precedes overflow or underflow.
- busy = (state==RUN)||(state==HOLD). done is never asserted together with busy.

Test Plan:
- Async reset mid-run: WIDTH=4, up, limit=9. Assert reset between edges at count=5 → count=0, toggle=0, busy=0 immediately (before the next edge); no done pulse ever follows.
- Up run: WIDTH=4, dir=0, limit=3, start pulsed 1 cycle → count 0,1,2,3 on successive edges; toggle sequence 0001,0011,0001,0000; done high exactly 1 cycle after count=3 is reached, then IDLE with count=3.
- Down run with carry: WIDTH=4, dir=1, limit=8 → count 8,7,6,...,0; at count=8, toggle=1111 and next count=7; done once; busy low afterwards.
- Pause and resume: up, limit=15. Assert stop at count=6 → count 7 then frozen, toggle=0, busy=1. Hold 5 cycles, then pulse start → resumes 8,9,...,15, then done.
- Abort and simultaneous inputs:
  - start=stop=1 in IDLE → stays IDLE.
  - start=stop=1 in RUN → HOLD.
  - stop in HOLD → IDLE, count retained, done never asserted.
- Boundary: limit=0, start → RUN for 1 cycle with toggle=0, then DONE (done=1), then IDLE, with count=0 throughout. Changing limit to 5 mid-run of another sequence does not alter its terminal.

Source files
------------

// File: rtl/toggle_seq_ctrl.sv
// Start/pause/resume controller for a bank of T-type bits counting between 0 and a latched limit.
// Emits per-bit toggle enables each cycle and a one-cycle done pulse when the run completes.
//
// state | meaning
// IDLE  | waiting for start; count holds its last value
// RUN   | advancing count one step per cycle toward terminal
// HOLD  | paused; start resumes, stop aborts
// DONE  | terminal reached; one-cycle done pulse
module toggle_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] toggle,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t           state, state_nxt;
  logic             dir_q;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] terminal;
  logic             at_term;
  logic             load;

  assign terminal = dir_q ? '0 : limit_q;
  assign at_term  = (count == terminal);
  assign busy     = (state == RUN) || (state == HOLD);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      dir_q   <= 1'b0;
      limit_q <= '0;
      count   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        dir_q   <= dir;
        limit_q <= limit;
        count   <= dir ? limit : '0;
      end else begin
        count <= count ^ toggle;
      end
    end
  end

  // A bit toggles when every lower bit is all-ones (up) or all-zeros (down).
  always_comb begin
    logic all_ones;
    logic all_zeros;
    toggle    = '0;
    all_ones  = 1'b1;
    all_zeros = 1'b1;
    if (state == RUN && !at_term) begin
      toggle[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
        all_ones  = all_ones & count[i-1];
        all_zeros = all_zeros & ~count[i-1];
        toggle[i] = dir_q ? all_zeros : all_ones;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (stop)         state_nxt = HOLD;
        else if (at_term) state_nxt = DONE;
      end
      HOLD: begin
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = RUN;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_toggle_seq_ctrl.sv
// Bench for toggle_seq_ctrl: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against an arithmetic reference model.
module tb_toggle_seq_ctrl;
  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, stop, dir;
  logic [W-1:0] limit;
  logic [W-1:0] toggle, count;
  logic         busy, done;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  toggle_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir),
    .limit(limit), .toggle(toggle), .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: three activity flags and an integer count; idle is all flags clear.
  bit m_running, m_paused, m_finishing, m_dir;
  int m_count, m_lim;

  function automatic int m_term();
    return m_dir ? 0 : m_lim;
  endfunction

  function automatic int m_stepped();
    if (m_running && m_count != m_term()) return m_dir ? m_count - 1 : m_count + 1;
    return m_count;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_running <= 0; m_paused <= 0; m_finishing <= 0;
      m_dir <= 0; m_count <= 0; m_lim <= 0;
    end else if (m_finishing) begin
      m_finishing <= 0;
    end else if (m_running) begin
      if (stop) begin
        m_running <= 0; m_paused <= 1; m_count <= m_stepped();
      end else if (m_count == m_term()) begin
        m_running <= 0; m_finishing <= 1;
      end else begin
        m_count <= m_stepped();
      end
    end else if (m_paused) begin
      if (stop) m_paused <= 0;
      else if (start) begin m_paused <= 0; m_running <= 1; end
    end else if (start && !stop) begin
      m_running <= 1; m_dir <= dir; m_lim <= int'(limit);
      m_count <= dir ? int'(limit) : 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && model_on) begin
      chk("model_count", int'(count), m_count);
      chk("model_toggle", int'(toggle), (m_count ^ m_stepped()) & MASK);
      chk("model_busy", int'(busy), int'(m_running || m_paused));
      chk("model_done", int'(done), int'(m_finishing));
      if (done && busy) chk("done_with_busy", 1, 0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go(input bit d, input int l);
    start = 1; stop = 0; dir = d; limit = W'(l);
    tick();
    start = 0;
  endtask

  task automatic wait_count(input int v, input int budget);
    int n = 0;
    while (int'(count) != v && n < budget) begin tick(); n++; end
    if (int'(count) != v) chk("wait_count_timeout", int'(count), v);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    chk("wait_done", int'(done), 1);
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; dir = 0; limit = '0;
    model_on = 1;
    tick(); tick();
    reset = 0;
    tick();
    chk("rst_count", int'(count), 0);
    chk("rst_toggle", int'(toggle), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    // Up run to 3
    go(0, 3);
    chk("up_c0", int'(count), 0); chk("up_t0", int'(toggle), 4'b0001);
    tick(); chk("up_c1", int'(count), 1); chk("up_t1", int'(toggle), 4'b0011);
    tick(); chk("up_c2", int'(count), 2); chk("up_t2", int'(toggle), 4'b0001);
    tick(); chk("up_c3", int'(count), 3); chk("up_t3", int'(toggle), 0);
    chk("up_busy3", int'(busy), 1);
    tick(); chk("up_done", int'(done), 1); chk("up_busy_d", int'(busy), 0);
    tick(); chk("up_done_off", int'(done), 0); chk("up_hold3", int'(count), 3);

    // Down run from 8 with full borrow
    go(1, 8);
    chk("dn_c8", int'(count), 8); chk("dn_t8", int'(toggle), 4'b1111);
    tick(); chk("dn_c7", int'(count), 7);
    wait_done(20);
    chk("dn_end", int'(count), 0);
    tick(); chk("dn_busy", int'(busy), 0);

    // Pause at 6, hold, resume
    go(0, 15);
    wait_count(6, 20);
    stop = 1; tick(); stop = 0;
    chk("ps_c7", int'(count), 7); chk("ps_t", int'(toggle), 0); chk("ps_busy", int'(busy), 1);
    repeat (5) tick();
    chk("ps_frozen", int'(count), 7);
    start = 1; tick(); start = 0;
    tick(); chk("ps_c8", int'(count), 8);
    wait_done(20);
    chk("ps_end", int'(count), 15);
    tick();

    // Simultaneous start/stop in IDLE, then in RUN, then abort from HOLD
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    chk("ss_idle", int'(busy), 0);
    go(0, 15);
    tick();
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    chk("ss_run_busy", int'(busy), 1); chk("ss_run_t", int'(toggle), 0);
    chk("ss_run_c", int'(count), 2);
    stop = 1; tick(); stop = 0;
    chk("ab_busy", int'(busy), 0); chk("ab_count", int'(count), 2);
    repeat (3) begin tick(); chk("ab_nodone", int'(done), 0); end

    // limit = 0
    go(0, 0);
    chk("z_busy", int'(busy), 1); chk("z_t", int'(toggle), 0); chk("z_c", int'(count), 0);
    tick(); chk("z_done", int'(done), 1); chk("z_c2", int'(count), 0);
    tick(); chk("z_idle", int'(done | busy), 0);

    // Mid-run limit/dir change ignored
    go(0, 9);
    tick(); limit = 5; dir = 1;
    wait_done(20);
    chk("lim_end", int'(count), 9);
    tick();

    // Async reset mid-run
    go(0, 9);
    wait_count(5, 20);
    #2 reset = 1;
    #1;
    chk("ar_count", int'(count), 0); chk("ar_toggle", int'(toggle), 0);
    chk("ar_busy", int'(busy), 0);
    tick(); reset = 0;
    repeat (12) begin tick(); chk("ar_nodone", int'(done), 0); end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 9) == 0);
      dir   = $urandom_range(0, 1);
      limit = W'($urandom_range(0, MASK));
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1; tick(); reset = 0;
      end else begin
        tick();
      end
    end
    start = 0; stop = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
